// File: rtl/disp_scan8_if.sv
// Display-word and pin-side signals of the 8-digit scan driver.
// The mapper side drives valor; the driver side produces the pins.
interface disp_scan8_if;
    logic [31:0] valor;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    modport master (output valor, input an, seg, dp, frame_tick);
    modport slave  (input valor, output an, seg, dp, frame_tick);
endinterface

// File: rtl/disp_scan8.sv
// Eight-digit multiplexed common-anode 7-segment scanner.
// The display word is latched once per frame, and anodes are blanked at each slot start.
module disp_scan8 #(
    parameter int DIV   = 100000,
    parameter int BLANK = 8
) (
    input logic         clk,
    input logic         rst,
    disp_scan8_if.slave bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          frame_tick_q, frame_tick_d;

    logic          slot_end;
    logic          frame_end;
    logic          blank_w;
    logic [3:0]    nib;
    logic [6:0]    pat;

    generate
        if (BLANK == 0) begin : g_noblank
            assign blank_w = 1'b0;
        end else begin : g_blank
            assign blank_w = (cnt_q < CW'(BLANK));
        end
    endgenerate

    // Digit 7 is the numeric octave digit; the others use the note-text glyph set.
    function automatic logic [6:0] decode(input logic numeric, input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = numeric ? 7'h7D : 7'h50;
            4'h7: p = numeric ? 7'h07 : 7'h38;
            4'h8: p = numeric ? 7'h7F : 7'h37;
            4'h9: p = numeric ? 7'h6F : 7'h00;
            4'hA: p = 7'h77;
            4'hB: p = numeric ? 7'h7C : 7'h76;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == 3'd7);
    assign nib       = shadow_q[{idx_q, 2'b00} +: 4];
    assign pat       = decode(idx_q == 3'd7, nib);

    always_comb begin
        cnt_d        = slot_end ? '0 : cnt_q + 1'b1;
        idx_d        = slot_end ? idx_q + 3'd1 : idx_q;
        shadow_d     = frame_end ? bus.valor : shadow_q;
        an_d         = blank_w ? 8'hFF : ~(8'h01 << idx_q);
        seg_d        = ~pat;
        frame_tick_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            shadow_q     <= 32'h0999_9999;
            an_q         <= 8'hFF;
            seg_q        <= 7'h7F;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = 1'b1;
    assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_disp_scan8.sv
// Bench for disp_scan8: two instances (DIV=4/BLANK=1 and DIV=2/BLANK=0) checked
// every cycle against a time-based model of the scan, latch and decode rules.
module tb_disp_scan8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    disp_scan8_if bus_a ();
    disp_scan8_if bus_b ();

    disp_scan8 #(.DIV(4), .BLANK(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    disp_scan8 #(.DIV(2), .BLANK(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    always #5 clk = ~clk;

    logic [6:0] num_t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [6:0] gly_t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h50, 7'h38,
                               7'h37, 7'h00, 7'h77, 7'h76, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: edges since reset released, and the word shown in the current frame.
    int          n_a, n_b;
    logic [31:0] sh_a, sh_b;
    int          ticks_a;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_chk(input string pfx, input int div, input int blank,
                             input logic rst_v, input logic [31:0] v,
                             inout int n, inout logic [31:0] sh,
                             input logic [7:0] o_an, input logic [6:0] o_seg,
                             input logic o_dp, input logic o_ft);
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_ft;
        logic [3:0] nb;
        int t, idx;
        if (rst_v) begin
            n = 0;
            sh = 32'h0999_9999;
            e_an = 8'hFF; e_seg = 7'h7F; e_ft = 1'b0;
        end else begin
            n++;
            t   = n - 1;
            idx = (t / div) % 8;
            e_an  = ((t % div) < blank) ? 8'hFF : ~(8'h01 << idx);
            nb    = sh[idx*4 +: 4];
            e_seg = ~((idx == 7) ? num_t[nb] : gly_t[nb]);
            e_ft  = ((t % (8*div)) == (8*div - 1));
            if ((n % (8*div)) == 0) sh = v;
        end
        chk({pfx, ".an"}, o_an, e_an);
        chk({pfx, ".seg"}, {1'b0, o_seg}, {1'b0, e_seg});
        chk({pfx, ".dp"}, {7'd0, o_dp}, 8'h01);
        chk({pfx, ".frame_tick"}, {7'd0, o_ft}, {7'd0, e_ft});
    endtask

    task automatic cycle(input logic rst_v, input logic [31:0] v);
        @(negedge clk);
        rst = rst_v;
        bus_a.valor = v;
        bus_b.valor = v;
        @(posedge clk);
        #1;
        model_chk("a", 4, 1, rst_v, v, n_a, sh_a,
                  bus_a.an, bus_a.seg, bus_a.dp, bus_a.frame_tick);
        model_chk("b", 2, 0, rst_v, v, n_b, sh_b,
                  bus_b.an, bus_b.seg, bus_b.dp, bus_b.frame_tick);
        if (bus_a.frame_tick === 1'b1) ticks_a++;
    endtask

    initial begin
        logic [31:0] v;
        bus_a.valor = 32'h0;
        bus_b.valor = 32'h0;
        n_a = 0; n_b = 0;
        sh_a = 32'h0999_9999; sh_b = 32'h0999_9999;
        ticks_a = 0;

        // Reset held three cycles, then one frame of the reset word.
        repeat (3) cycle(1'b1, 32'h0);
        repeat (32) cycle(1'b0, 32'h0);

        // Latch: two frames so the new word is shown in full.
        repeat (64) cycle(1'b0, 32'h3E5C_9D09);

        // Tear-free: old word latched, then changed while digit 3 is lit.
        repeat (44) cycle(1'b0, 32'h4E5C_96EB);
        repeat (60) cycle(1'b0, 32'h5E5C_97AB);

        // Mid-frame reset at digit 5, then count frame ticks afterwards.
        repeat (12) cycle(1'b0, 32'h1234_5678);
        cycle(1'b1, 32'h1234_5678);
        ticks_a = 0;
        repeat (80) cycle(1'b0, 32'h1234_5678);
        chk("a.ticks_after_reset", 8'(ticks_a), 8'd2);

        // Random words with occasional changes and rare resets.
        v = $urandom;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) v = $urandom;
            cycle(($urandom_range(0, 199) == 0), v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/disp_scan8.md
# disp_scan8

Eight-digit multiplexed 7-segment display driver for the note/octave readout. It accepts the 32-bit, eight-nibble display word produced by the note-to-text mapper and scans it onto a common-anode 8-digit display. Each nibble is translated into a segment pattern. The block sits between the mapper and the board's anode/segment pins. It latches the word once per frame so digits never tear, and blanks anodes at each digit change to suppress ghosting.

## Interface
Parameters:
- DIV, 100000: clock cycles per digit slot (1 ms at 100 MHz). Legal range is 2 or more.
- BLANK, 8: cycles at the start of each slot with all anodes off. Legal range is 0 ≤ BLANK < DIV.

Ports (clk and rst first):
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- valor  in  32  display word. Nibble k (bits 4k+3:4k) drives digit k. Digit 7 is leftmost.
- an  out  8  anode enables, active-low, one-hot-low. Bit k = digit k.
- seg  out  7  segments, active-low, ordered {g,f,e,d,c,b,a}.
- dp  out  1  decimal point, active-low. Always 1 (off).
- frame_tick  out  1  one-cycle pulse when a full 8-digit frame completes.

## Operation
State registers:
- cnt: prescaler, width $clog2(DIV), counts 0..DIV-1 and wraps.
- idx: 3-bit digit index. Increments when cnt==DIV-1. Wraps 7→0.
- shadow: 32-bit display latch. Loads valor on the edge where cnt==DIV-1 and idx==7 (frame boundary). Holds at all other times. Changes to valor mid-frame have no effect until the next boundary.

Decode, digit 7 (numeric mode): the nibble is shown as a hex glyph. Active-high gfedcba values:
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
- 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71

Decode, digits 6..0 (glyph mode), active-high gfedcba values:
- 0 'O'=3F, 1 'I'=06, 2=5B, 3=4F, 4=66, 5 'S'=6D, 6 'r'=50, 7 'L'=38
- 8 'M'=37, 9 blank=00, A 'A'=77, B '#'=76, C 'C'=39, D 'd'=5E, E 'E'=79, F 'F'=71

seg is the bitwise inverse of the decoded pattern.

Anode rule:
- While cnt < BLANK: an=FF.
- Otherwise: an = ~(1<<idx).

No state machine beyond the cnt/idx counters. Scan order is 0,1,…,7,0,… with no skips.

## Timing
Reset values (on the first edge with rst=1, held while rst=1):
- cnt=0, idx=0, shadow=32'h0999_9999.
- an=FF, seg=7F, dp=1, frame_tick=0.

Outputs are registered and computed from the pre-edge state, so there is one cycle of latency:
- an <= (cnt<BLANK) ? FF : ~(1<<idx)
- seg <= ~decode(idx, shadow nibble idx)
- frame_tick <= (cnt==DIV-1 && idx==7)

Frame timing:
- Each digit is driven for DIV cycles, BLANK of them dark. A frame is 8·DIV cycles.
- frame_tick is high exactly once per frame, in the cycle after the shadow load edge.
- The first frame after reset shows the reset shadow: digit 7 shows '0', digits 6..0 are blank.
- The first valor load occurs 8·DIV cycles after rst deasserts.
- If valor changes on the same edge as the load, the pre-edge value is captured.

Boundary cases:
- BLANK=0: anodes are never blanked.
- rst asserted mid-frame: the next edge restores all reset values. The partial frame is discarded, with no frame_tick.

## Test plan
Use DIV=4, BLANK=1 unless noted.
- Reset: hold rst for 3 cycles → an=FF, seg=7F, dp=1, frame_tick=0. First frame shows digit 7 seg=~3F=40; digits 0..6 seg=7F.
- Latch: apply valor=32'h3E5C_9D09, wait 2 frames → per slot:
  - digit 0: seg=7F (blank)
  - digit 1: seg=40 ('O')
  - digit 2: seg=21 ('d')
  - digit 3: seg=7F (blank)
  - digit 4: seg=46 ('C')
  - digit 5: seg=12 ('S')
  - digit 6: seg=06 ('E')
  - digit 7: seg=30 ('3')
- Anode/blank: observe one frame → each slot shows an=FF for 1 cycle, then ~(1<<k) for 3 cycles. Order is k=0..7. frame_tick pulses once per 32 cycles.
- Tear-free: change valor from 32'h4E5C_96EB to 32'h5E5C_97AB mid-frame (idx=3) → digits 4..7 in that frame still show the old value. The new value appears only after frame_tick.
- Mid-frame reset: assert rst at idx=5 for 1 cycle → next cycle an=FF, seg=7F. The scan restarts at digit 0 and shadow returns to 32'h0999_9999. frame_tick stays 0 until 32 cycles later.
- Edge params: DIV=2, BLANK=0 → an is never FF after reset. Each digit is lit for 2 cycles. The frame is 16 cycles.
